// File: rtl/panda_pkg.sv
// Shared definitions for the Panda execute stage: divider op encoding and op classifiers.
package panda_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_e;

    function automatic logic is_signed_op(div_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_rem_op(div_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/panda_adder.sv
// Two's-complement adder/subtractor; subtract_i selects a - b via inverted b and carry-in.
module panda_adder #(
    parameter int Width = 33
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             subtract_i,
    output logic [Width-1:0] sum_o
);

    logic [Width-1:0] b_eff;

    assign b_eff = subtract_i ? ~b_i : b_i;
    assign sum_o = a_i + b_eff + {{(Width-1){1'b0}}, subtract_i};

endmodule

// File: rtl/panda_divider.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle,
// with valid/ready handshakes on both the request and the result side.
module panda_divider
    import panda_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [Width-1:0] operand_a_i,
    input  logic [Width-1:0] operand_b_i,
    input  div_op_e          op_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] result_o
);

    localparam int CntW = $clog2(Width) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e           state_q, state_d;
    div_op_e          op_q, op_d;
    logic             a_neg_q, a_neg_d;
    logic             b_neg_q, b_neg_d;
    logic             fast_q, fast_d;
    logic [Width-1:0] quo_q, quo_d;
    logic [Width-1:0] rem_q, rem_d;
    logic [Width-1:0] dvs_q, dvs_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             accept;
    logic             signed_in, a_neg_in, b_neg_in;
    logic             div_zero, overflow;
    logic [Width-1:0] a_mag, b_mag;
    logic [Width:0]   partial, trial;
    logic             trial_ok;
    logic [Width-1:0] quo_fix, rem_fix;

    assign ready_o   = (state_q == IDLE);
    assign valid_o   = (state_q == DONE);
    assign accept    = valid_i && ready_o && !kill_i;

    assign signed_in = is_signed_op(op_i);
    assign a_neg_in  = signed_in && operand_a_i[Width-1];
    assign b_neg_in  = signed_in && operand_b_i[Width-1];
    assign a_mag     = a_neg_in ? -operand_a_i : operand_a_i;
    assign b_mag     = b_neg_in ? -operand_b_i : operand_b_i;
    assign div_zero  = (operand_b_i == '0);
    assign overflow  = signed_in && (operand_a_i == {1'b1, {(Width-1){1'b0}}})
                       && (operand_b_i == '1);

    // Partial remainder is one bit wider so the trial sign bit is the borrow.
    assign partial   = {rem_q, quo_q[Width-1]};
    assign trial_ok  = ~trial[Width];

    panda_adder #(.Width(Width + 1)) u_adder (
        .a_i       (partial),
        .b_i       ({1'b0, dvs_q}),
        .subtract_i(1'b1),
        .sum_o     (trial)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        fast_d  = fast_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = op_i;
                    a_neg_d = a_neg_in;
                    b_neg_d = b_neg_in;
                    dvs_d   = b_mag;
                    cnt_d   = '0;
                    if (div_zero) begin
                        quo_d   = '1;
                        rem_d   = operand_a_i;
                        fast_d  = 1'b1;
                        state_d = DONE;
                    end else if (overflow) begin
                        quo_d   = operand_a_i;
                        rem_d   = '0;
                        fast_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        quo_d   = a_mag;
                        rem_d   = '0;
                        fast_d  = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (kill_i) begin
                    state_d = IDLE;
                end else begin
                    quo_d = {quo_q[Width-2:0], trial_ok};
                    rem_d = trial_ok ? trial[Width-1:0] : partial[Width-1:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntW'(Width - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (kill_i || ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fast-path results are already final, so they bypass the sign fixup.
    always_comb begin
        quo_fix = quo_q;
        rem_fix = rem_q;
        if (!fast_q && is_signed_op(op_q)) begin
            if (a_neg_q ^ b_neg_q) quo_fix = -quo_q;
            if (a_neg_q)           rem_fix = -rem_q;
        end
        result_o = '0;
        if (state_q == DONE) begin
            result_o = is_rem_op(op_q) ? rem_fix : quo_fix;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= DIV;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            fast_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            fast_q  <= fast_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_panda_divider.sv
// Scoreboard bench for panda_divider: stimulus pushes expected results, a monitor pops and checks them.
module tb_panda_divider;
    import panda_pkg::*;

    localparam int W = 32;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         valid_i = 1'b0;
    logic         kill_i = 1'b0;
    logic         ready_i = 1'b1;
    logic         ready_o, valid_o;
    logic [W-1:0] operand_a_i = '0;
    logic [W-1:0] operand_b_i = '0;
    logic [W-1:0] result_o;
    div_op_e      op_i = DIVU;

    panda_divider #(.Width(W)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .operand_a_i(operand_a_i),
        .operand_b_i(operand_b_i),
        .op_i       (op_i),
        .kill_i     (kill_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    typedef struct {
        logic [W-1:0] res;
        int           acc;
        int           lat;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: first cycle of valid_o pops the scoreboard; later valid cycles check hold.
    initial begin
        exp_t         e;
        logic         seen;
        logic [W-1:0] held;
        string        cur;
        seen = 1'b0;
        held = '0;
        cur  = "";
        forever begin
            @(negedge clk_i);
            if (valid_o) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        check("spurious_valid", {31'd0, valid_o}, '0);
                    end else begin
                        e = sb.pop_front();
                        cur  = e.name;
                        held = e.res;
                        check({e.name, "_res"}, result_o, e.res);
                        check({e.name, "_lat"}, W'(cyc - e.acc + 1), W'(e.lat));
                        $display("txn %s result=%h latency=%0d", e.name, result_o, cyc - e.acc + 1);
                    end
                    seen = 1'b1;
                end else begin
                    check({cur, "_hold"}, result_o, held);
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    // Called at negedge+1; drives one request and returns just after its acceptance edge.
    task automatic issue(input div_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input int lat, input string name, input bit push);
        int n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk_i); #1;
            n++;
        end
        if (!ready_o) check({name, "_issue_timeout"}, {31'd0, ready_o}, W'(1));
        op_i        = op;
        operand_a_i = a;
        operand_b_i = b;
        valid_i     = 1'b1;
        if (push) sb.push_back('{res, cyc + 1, lat, name});
        @(negedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk_i); #1;
            n++;
        end
        check({name, "_idle"}, {31'd0, ready_o}, W'(1));
        check({name, "_drained"}, W'(sb.size()), '0);
    endtask

    task automatic run(input div_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input int lat, input string name);
        issue(op, a, b, res, lat, name, 1'b1);
        wait_idle(name);
    endtask

    initial begin
        int n;
        #1;
        check("rst_ready", {31'd0, ready_o}, W'(1));
        check("rst_valid", {31'd0, valid_o}, '0);
        check("rst_result", result_o, '0);
        repeat (2) @(negedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i); #1;

        run(DIVU, 32'd35, 32'd27, 32'd1, 33, "divu_35_27");
        run(REMU, 32'd35, 32'd27, 32'd8, 33, "remu_35_27");
        run(DIV, -32'sd45, 32'd12, 32'hFFFF_FFFD, 33, "div_m45_12");
        run(REM, -32'sd45, 32'd12, 32'hFFFF_FFF7, 33, "rem_m45_12");
        run(DIV, 32'd12, -32'sd19, 32'd0, 33, "div_12_m19");
        run(REM, 32'd12, -32'sd19, 32'd12, 33, "rem_12_m19");
        run(DIVU, 32'd12, 32'd0, 32'hFFFF_FFFF, 1, "divu_12_0");
        run(REM, -32'sd7, 32'd0, 32'hFFFF_FFF9, 1, "rem_m7_0");
        run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
        run(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "divu_big_max");
        run(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_max_1");
        run(DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33, "div_min_2");
        run(REM, -32'sd7, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
        run(DIVU, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 33, "divu_big_3");
        run(REMU, 32'h8000_0000, 32'd3, 32'd2, 33, "remu_big_3");

        // kill in IDLE must block the request
        op_i = DIVU; operand_a_i = 32'd5; operand_b_i = 32'd1;
        valid_i = 1'b1; kill_i = 1'b1;
        @(negedge clk_i); #1;
        valid_i = 1'b0; kill_i = 1'b0;
        check("kill_idle_ready", {31'd0, ready_o}, W'(1));

        // kill at CALC iteration 10
        issue(DIV, 32'd1000, 32'd3, '0, 0, "killed", 1'b0);
        repeat (9) begin @(negedge clk_i); #1; end
        kill_i = 1'b1;
        @(negedge clk_i); #1;
        kill_i = 1'b0;
        check("kill_calc_ready", {31'd0, ready_o}, W'(1));
        check("kill_calc_valid", {31'd0, valid_o}, '0);
        repeat (40) begin @(negedge clk_i); #1; end

        // backpressure then back-to-back
        ready_i = 1'b0;
        issue(DIVU, 32'd100, 32'd7, 32'd14, 33, "bp_divu", 1'b1);
        n = 0;
        while (!valid_o && n < 100) begin @(negedge clk_i); #1; n++; end
        check("bp_valid_seen", {31'd0, valid_o}, W'(1));
        repeat (5) begin
            @(negedge clk_i); #1;
            check("bp_valid_held", {31'd0, valid_o}, W'(1));
            check("bp_ready_low", {31'd0, ready_o}, '0);
        end
        ready_i = 1'b1;
        @(negedge clk_i); #1;
        check("bp_release_idle", {31'd0, ready_o}, W'(1));
        run(REMU, 32'd100, 32'd7, 32'd2, 33, "b2b_remu");

        // asynchronous reset at iteration 20
        issue(DIV, 32'd1000, 32'd3, '0, 0, "reset_mid", 1'b0);
        repeat (19) begin @(negedge clk_i); #1; end
        rst_ni = 1'b0;
        #1;
        check("arst_valid", {31'd0, valid_o}, '0);
        check("arst_ready", {31'd0, ready_o}, W'(1));
        check("arst_result", result_o, '0);
        @(negedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i); #1;
        run(DIVU, 32'd35, 32'd27, 32'd1, 33, "post_reset");

        repeat (3) @(negedge clk_i);
        check("final_drained", W'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
